// File: rtl/sevenseg_scan_counter.sv
// ---------------------------------------------------------------------------
// sevenseg_scan_counter
//
// BCD up/down counter driving a multiplexed, common-scan seven-segment
// display. A free-running tick divider paces the count; a separate refresh
// divider walks a scan index across the digits. The selected digit is
// decoded (with optional leading-zero blanking) into registered outputs.
//
// Ports:
//   clk          : clock, rising edge
//   rst_n        : synchronous active-low reset
//   en           : count enable (ticks ignored while low)
//   up           : count direction, 1 = increment, 0 = decrement
//   load         : load strobe, takes priority over a tick
//   load_val     : BCD load value, digit 0 in [3:0]; digits > 9 load as 0
//   display      : segments {a,b,c,d,e,f,g}, active-low, registered
//   digit_select : one-hot active-high digit enable, registered
//   value        : current BCD count, registered
//   wrap         : one-cycle pulse when the count wraps around
// ---------------------------------------------------------------------------
module sevenseg_scan_counter #(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 135000,
   parameter int TICK_DIV    = 2700000,
   parameter int BLANK_LZ    = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  up,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [6:0]            display,
   output logic [DIGITS-1:0]     digit_select,
   output logic [4*DIGITS-1:0]   value,
   output logic                  wrap
);

   localparam int VW    = 4 * DIGITS;
   localparam int TW    = $clog2(TICK_DIV);
   localparam int RW    = $clog2(REFRESH_DIV);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DIGITS - 1);
   localparam logic [VW-1:0]    ALL_NINES = {DIGITS{4'h9}};

   function automatic logic [VW-1:0] bcd_sanitize(input logic [VW-1:0] v);
      logic [VW-1:0] r;
      r = v;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd0;
      end
      return r;
   endfunction

   function automatic logic [VW-1:0] bcd_inc(input logic [VW-1:0] v);
      logic [VW-1:0] r;
      logic          c;
      logic [3:0]    d;
      r = v;
      c = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         d = v[4*i +: 4];
         if (c) begin
            if (d == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = d + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [VW-1:0] bcd_dec(input logic [VW-1:0] v);
      logic [VW-1:0] r;
      logic          b;
      logic [3:0]    d;
      r = v;
      b = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         d = v[4*i +: 4];
         if (b) begin
            if (d == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = d - 4'd1;
               b = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [6:0] seg_encode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b0000001;
         4'd1:    s = 7'b1001111;
         4'd2:    s = 7'b0010010;
         4'd3:    s = 7'b0000110;
         4'd4:    s = 7'b1001100;
         4'd5:    s = 7'b0100100;
         4'd6:    s = 7'b0100000;
         4'd7:    s = 7'b0001111;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0000100;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   logic [TW-1:0]    tick_cnt;
   logic [RW-1:0]    ref_cnt;
   logic [IDX_W-1:0] scan_idx;
   logic             tick;
   logic             ref_tc;
   logic [VW-1:0]    shifted;
   logic             blank;
   logic [6:0]       disp_nxt;
   logic [DIGITS-1:0] sel_nxt;

   assign tick   = (tick_cnt == TW'(TICK_DIV - 1));
   assign ref_tc = (ref_cnt == RW'(REFRESH_DIV - 1));

   // ---- stage 0: dividers, scan index and the count register ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tick_cnt <= '0;
         ref_cnt  <= '0;
         scan_idx <= '0;
         value    <= '0;
         wrap     <= 1'b0;
      end else begin
         tick_cnt <= tick   ? '0 : tick_cnt + 1'b1;
         ref_cnt  <= ref_tc ? '0 : ref_cnt + 1'b1;
         if (ref_tc) scan_idx <= (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
         wrap <= 1'b0;
         if (load) begin
            value <= bcd_sanitize(load_val);
         end else if (tick && en) begin
            if (up) begin
               value <= bcd_inc(value);
               wrap  <= (value == ALL_NINES);
            end else begin
               value <= bcd_dec(value);
               wrap  <= (value == '0);
            end
         end
      end
   end

   // Shifting the selected digit down to bit 0 also tells us whether it and
   // every higher digit are zero, which is exactly the leading-zero test.
   always_comb begin
      shifted  = value >> {scan_idx, 2'b00};
      blank    = (BLANK_LZ != 0) && (scan_idx != '0) && (shifted == '0);
      disp_nxt = blank ? 7'b1111111 : seg_encode(shifted[3:0]);
      sel_nxt  = DIGITS'(1) << scan_idx;
   end

   // ---- stage 1: registered display drive ----
   // Decoding from the whole registered count means a digit is never shown
   // mid-update; a new value appears at that digit's next refresh.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         display      <= 7'b1111111;
         digit_select <= '0;
      end else begin
         display      <= disp_nxt;
         digit_select <= sel_nxt;
      end
   end

endmodule

// File: tb/tb_sevenseg_scan_counter.sv
module tb_sevenseg_scan_counter;

   localparam int A_D = 4, A_R = 4, A_T = 3;
   localparam int B_D = 1, B_R = 2, B_T = 2;

   typedef struct {
      logic [31:0] value;
      logic        wrap;
      logic [6:0]  disp;
      logic [7:0]  sel;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0, en = 1'b0, up = 1'b1, load = 1'b0;
   logic [15:0] lv_a = '0;
   logic [3:0]  lv_b;
   logic [6:0]  disp_a, disp_b;
   logic [3:0]  sel_a;
   logic [0:0]  sel_b;
   logic [15:0] val_a;
   logic [3:0]  val_b;
   logic        wrap_a, wrap_b;

   exp_t qa[$];
   exp_t qb[$];
   int   checks = 0;
   int   errors = 0;
   int   cur_a = 0, t_a = 0, cur_b = 0, t_b = 0;

   assign lv_b = lv_a[3:0];

   always #5 clk = ~clk;

   sevenseg_scan_counter #(.DIGITS(A_D), .REFRESH_DIV(A_R), .TICK_DIV(A_T), .BLANK_LZ(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(lv_a),
      .display(disp_a), .digit_select(sel_a), .value(val_a), .wrap(wrap_a));

   sevenseg_scan_counter #(.DIGITS(B_D), .REFRESH_DIV(B_R), .TICK_DIV(B_T), .BLANK_LZ(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(lv_b),
      .display(disp_b), .digit_select(sel_b), .value(val_b), .wrap(wrap_b));

   function automatic logic [6:0] seg(input int d);
      case (d)
         0: return 7'b0000001;
         1: return 7'b1001111;
         2: return 7'b0010010;
         3: return 7'b0000110;
         4: return 7'b1001100;
         5: return 7'b0100100;
         6: return 7'b0100000;
         7: return 7'b0001111;
         8: return 7'b0000000;
         9: return 7'b0000100;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [31:0] to_bcd(input int c);
      logic [31:0] r;
      int          x;
      r = '0;
      x = c;
      for (int i = 0; i < 8; i++) begin
         r = r | (32'(x % 10) << (4 * i));
         x = x / 10;
      end
      return r;
   endfunction

   // Reference model: the count is a plain decimal integer, time is the
   // number of clock edges since reset release.
   task automatic model_edge(input int D, input int R, input int TK, input bit blk,
                             input logic rn, input logic en_i, input logic up_i,
                             input logic ld, input logic [31:0] lv,
                             inout int cur, inout int t, output exp_t e);
      int maxv, idx, p, nv, n;
      maxv = 1;
      for (int i = 0; i < D; i++) maxv = maxv * 10;
      maxv = maxv - 1;
      e.wrap = 1'b0;
      if (!rn) begin
         cur = 0;
         t = 0;
         e.disp = 7'b1111111;
         e.sel = 8'h00;
      end else begin
         idx = (t / R) % D;
         p = 1;
         for (int i = 0; i < idx; i++) p = p * 10;
         e.sel = 8'(1 << idx);
         if (blk && idx > 0 && (cur / p) == 0) e.disp = 7'b1111111;
         else e.disp = seg((cur / p) % 10);
         if (ld) begin
            nv = 0;
            p = 1;
            for (int i = 0; i < D; i++) begin
               n = int'((lv >> (4 * i)) & 32'hF);
               nv = nv + ((n > 9) ? 0 : n) * p;
               p = p * 10;
            end
            cur = nv;
         end else if ((t % TK) == TK - 1 && en_i) begin
            if (up_i) begin
               if (cur == maxv) begin cur = 0; e.wrap = 1'b1; end
               else cur = cur + 1;
            end else begin
               if (cur == 0) begin cur = maxv; e.wrap = 1'b1; end
               else cur = cur - 1;
            end
         end
         t = t + 1;
      end
      e.value = to_bcd(cur);
   endtask

   task automatic drive(input logic rn, input logic en_i, input logic up_i,
                        input logic ld, input logic [15:0] lv);
      exp_t ea, eb;
      @(negedge clk);
      rst_n = rn; en = en_i; up = up_i; load = ld; lv_a = lv;
      model_edge(A_D, A_R, A_T, 1'b1, rn, en_i, up_i, ld, 32'(lv), cur_a, t_a, ea);
      model_edge(B_D, B_R, B_T, 1'b0, rn, en_i, up_i, ld, 32'(lv[3:0]), cur_b, t_b, eb);
      qa.push_back(ea);
      qb.push_back(eb);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every cycle the DUTs present a full set of outputs.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (qa.size() > 0) begin
         e = qa.pop_front();
         check("a_value", 32'(val_a), e.value);
         check("a_wrap", 32'(wrap_a), 32'(e.wrap));
         check("a_display", 32'(disp_a), 32'(e.disp));
         check("a_digit_select", 32'(sel_a), 32'(e.sel));
      end
      if (qb.size() > 0) begin
         e = qb.pop_front();
         check("b_value", 32'(val_b), e.value);
         check("b_wrap", 32'(wrap_b), 32'(e.wrap));
         check("b_display", 32'(disp_b), 32'(e.disp));
         check("b_digit_select", 32'(sel_b), 32'(e.sel));
      end
   end

   initial begin
      // reset, then free counting up
      drive(0, 1, 1, 0, 16'h0);
      drive(0, 1, 1, 0, 16'h0);
      for (int i = 0; i < 24; i++) drive(1, 1, 1, 0, 16'h0);
      // 0099 then tick up -> 0100; B loads 9 and wraps to 0
      drive(1, 1, 1, 1, 16'h0099);
      for (int i = 0; i < 20; i++) drive(1, 1, 1, 0, 16'h0);
      // 9999 wraps up, 0000 wraps down
      drive(1, 1, 1, 1, 16'h9999);
      for (int i = 0; i < 6; i++) drive(1, 1, 1, 0, 16'h0);
      drive(1, 1, 0, 1, 16'h0000);
      for (int i = 0; i < 18; i++) drive(1, 1, 0, 0, 16'h0);
      // load coincident with a tick
      for (int k = 0; k < 5 && (t_a % A_T) != A_T - 1; k++) drive(1, 1, 1, 0, 16'h0);
      drive(1, 1, 1, 1, 16'h12A4);
      for (int i = 0; i < 4; i++) drive(1, 1, 1, 0, 16'h0);
      // disabled across many ticks
      for (int i = 0; i < 32; i++) drive(1, 0, 1, 0, 16'h0);
      // single-cycle reset mid-scan
      for (int i = 0; i < 5; i++) drive(1, 1, 1, 0, 16'h0);
      drive(0, 1, 1, 1, 16'h5555);
      for (int i = 0; i < 20; i++) drive(1, 1, 1, 0, 16'h0);
      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         drive(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
               16'($urandom));
      end
      drive(1, 0, 1, 0, 16'h0);
      @(negedge clk);
      @(negedge clk);
      check("queues_drained", 32'(qa.size() + qb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
